// File: rtl/fma_stream_pkg.sv
// Shared types and constants for the FMA streaming controller.
// Optional tag path is enabled by defining FMA_STREAM_TAG_EN.
package fma_stream_pkg;

   localparam int FMA_PIPE_LAT = 5;
   localparam int FP32_W       = 32;

   typedef logic [FP32_W-1:0] fp32_t;

   typedef struct packed {
      fp32_t a;
      fp32_t b;
      fp32_t c;
   } fma_ops_t;

endpackage

// File: rtl/fma_stream_ctrl_if.sv
// Operand/result valid-ready bundle between a producer/consumer and the
// FMA streaming controller. Tag signals exist only with FMA_STREAM_TAG_EN.
interface fma_stream_ctrl_if
`ifdef FMA_STREAM_TAG_EN
   #(parameter int TAG_W = 4)
`endif
   ;
   import fma_stream_pkg::*;

   logic  in_valid;
   logic  in_ready;
   fp32_t in_a;
   fp32_t in_b;
   fp32_t in_c;
   logic  out_valid;
   logic  out_ready;
   fp32_t out_result;
`ifdef FMA_STREAM_TAG_EN
   logic [TAG_W-1:0] in_tag;
   logic [TAG_W-1:0] out_tag;
`endif

   // Producer of operands and consumer of results.
   modport master (
      output in_valid, in_a, in_b, in_c,
      input  in_ready,
      input  out_valid, out_result,
`ifdef FMA_STREAM_TAG_EN
      output in_tag,
      input  out_tag,
`endif
      output out_ready
   );

   // The controller itself.
   modport slave (
      input  in_valid, in_a, in_b, in_c,
      output in_ready,
      output out_valid, out_result,
`ifdef FMA_STREAM_TAG_EN
      input  in_tag,
      output out_tag,
`endif
      input  out_ready
   );

endinterface

// File: rtl/fma_result_fifo.sv
// Circular-buffer result FIFO with push/pop/count. Read data is the head
// entry (no fall-through) and reads as zero while empty.
module fma_result_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Storage write at the tail.
   // NOTE: storage is not reset; cnt gates pop_data so stale entries never show.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointer and fill-count update; reset empties the buffer.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign count    = cnt;
   assign pop_data = (cnt == '0) ? '0 : mem[rd_ptr];

   // The credit counter upstream must make overflow/underflow impossible.
   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(push && (cnt == CNT_W'(DEPTH))));
   a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
      !(pop && (cnt == '0)));

endmodule

// File: rtl/fma_stream_ctrl.sv
// Valid/ready front-end and result buffer for a fixed-latency FMA pipeline
// that cannot stall. A credit counter (occ) covers in-flight ops plus FIFO
// entries so the FIFO can never overflow. Defining FMA_STREAM_TAG_EN adds a
// tag that travels with each op and is returned alongside its result.
module fma_stream_ctrl
   import fma_stream_pkg::*;
#(
   parameter int FMA_LAT = FMA_PIPE_LAT,
   parameter int DEPTH   = 8
`ifdef FMA_STREAM_TAG_EN
   , parameter int TAG_W = 4
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   fma_stream_ctrl_if.slave           bus,
   output fp32_t                      fma_a,
   output fp32_t                      fma_b,
   output fp32_t                      fma_c,
   input  fp32_t                      fma_result,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int OCC_W = $clog2(DEPTH + 1);
`ifdef FMA_STREAM_TAG_EN
   localparam int DATA_W = FP32_W + TAG_W;
`else
   localparam int DATA_W = FP32_W;
`endif

   logic               fire_in;
   logic               fire_out;
   logic [OCC_W-1:0]   occ;
   logic [OCC_W-1:0]   fifo_count;
   logic [FMA_LAT-1:0] vld_sr;
   logic [DATA_W-1:0]  fifo_wdata;
   logic [DATA_W-1:0]  fifo_rdata;
   fma_ops_t           ops_in;
   fma_ops_t           ops_drv;

   // in_ready depends only on registered credit state (and rst), never on out_ready.
   assign bus.in_ready = ~rst & (occ < OCC_W'(DEPTH));
   assign fire_in      = bus.in_valid & bus.in_ready;
   assign fire_out     = bus.out_valid & bus.out_ready;

   assign ops_in = '{a: bus.in_a, b: bus.in_b, c: bus.in_c};

   // Operands reach the datapath only on an accepted transfer, zero otherwise.
   // NOTE: default assigned first so no path through the block infers a latch.
   always_comb begin
      ops_drv = '0;
      if (fire_in) ops_drv = ops_in;
   end

   assign fma_a = ops_drv.a;
   assign fma_b = ops_drv.b;
   assign fma_c = ops_drv.c;

   // Credit counter: +1 per accepted op, -1 per delivered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ <= '0;
      end else begin
         case ({fire_in, fire_out})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   assign occupancy = occ;

   // Valid tracking through the pipeline; cleared on reset so late results are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_sr <= '0;
      end else begin
         vld_sr[0] <= fire_in;
         for (int i = 1; i < FMA_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      end
   end

`ifdef FMA_STREAM_TAG_EN
   logic [TAG_W-1:0] tag_sr [FMA_LAT];

   // Tag delay line in lockstep with vld_sr; contents matter only where vld_sr is set.
   always_ff @(posedge clk) begin
      tag_sr[0] <= bus.in_tag;
      for (int i = 1; i < FMA_LAT; i++) tag_sr[i] <= tag_sr[i-1];
   end

   assign fifo_wdata  = {tag_sr[FMA_LAT-1], fma_result};
   assign bus.out_tag = fifo_rdata[DATA_W-1:FP32_W];
`else
   assign fifo_wdata  = fma_result;
`endif

   fma_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (vld_sr[FMA_LAT-1]),
      .push_data (fifo_wdata),
      .pop       (fire_out),
      .pop_data  (fifo_rdata),
      .count     (fifo_count)
   );

   assign bus.out_valid  = (fifo_count != '0);
   assign bus.out_result = fifo_rdata[FP32_W-1:0];

endmodule

// File: tb/tb_fma_stream_ctrl.sv
// Testbench for fma_stream_ctrl. Contains a 5-stage FMA stand-in that works
// on integer-valued single-precision operands. Scoreboard queue is filled by
// the driver on acceptance and drained by an independent output monitor.
// Tag checks are compiled in with FMA_STREAM_TAG_EN.
module tb_fma_stream_ctrl;
   import fma_stream_pkg::*;

   localparam int LAT   = 5;
   localparam int DEPTH = 8;
`ifdef FMA_STREAM_TAG_EN
   localparam int TAG_W = 4;
`endif

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   fp32_t fma_a, fma_b, fma_c, fma_result;
   logic [$clog2(DEPTH+1)-1:0] occupancy;

   always #5 clk = ~clk;

`ifdef FMA_STREAM_TAG_EN
   fma_stream_ctrl_if #(.TAG_W(TAG_W)) bus ();
   fma_stream_ctrl #(.FMA_LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
`else
   fma_stream_ctrl_if bus ();
   fma_stream_ctrl #(.FMA_LAT(LAT), .DEPTH(DEPTH)) dut (
`endif
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .fma_a      (fma_a),
      .fma_b      (fma_b),
      .fma_c      (fma_c),
      .fma_result (fma_result),
      .occupancy  (occupancy)
   );

   // ---------------- integer-valued fp32 helpers ----------------
   function automatic int unsigned dec(input fp32_t f);
      int          e;
      logic [31:0] m;
      if (f[30:0] == 31'd0) return 0;
      e = int'(f[30:23]) - 127;
      if (e < 0 || e > 23) return 0;
      m = {8'd0, 1'b1, f[22:0]};
      return m >> (23 - e);
   endfunction

   function automatic fp32_t enc(input int unsigned n);
      int          p;
      logic [31:0] m;
      if (n == 0) return '0;
      p = 0;
      for (int i = 0; i < 32; i++) if (n[i]) p = i;
      m = n << (23 - p);
      return {1'b0, 8'(p + 127), m[22:0]};
   endfunction

   // ---------------- FMA pipeline stand-in (no reset, no stall) ----------------
   fp32_t stub_pipe [LAT];
   always @(posedge clk) begin
      stub_pipe[0] <= enc(dec(fma_a) * dec(fma_b) + dec(fma_c));
      for (int k = 1; k < LAT; k++) stub_pipe[k] <= stub_pipe[k-1];
   end
   assign fma_result = stub_pipe[LAT-1];

   // ---------------- scoreboard ----------------
   int    n_checks = 0;
   int    n_errors = 0;
   int    n_pops   = 0;
   fp32_t exp_q [$];
`ifdef FMA_STREAM_TAG_EN
   logic [TAG_W-1:0] tag_q [$];
   logic [TAG_W-1:0] cur_tag = '0;
   logic [TAG_W-1:0] hold_tag;
`endif
   logic  hold_prev = 1'b0;
   fp32_t hold_val;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Output monitor: compares every delivered result and checks hold stability.
   always @(negedge clk) begin
      fp32_t want;
      if (rst) begin
         hold_prev <= 1'b0;
      end else begin
         if (bus.out_valid && hold_prev) begin
            check("hold_result", bus.out_result, hold_val);
`ifdef FMA_STREAM_TAG_EN
            check("hold_tag", 32'(bus.out_tag), 32'(hold_tag));
`endif
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_output: got %h, expected no output", bus.out_result);
            end else begin
               want = exp_q.pop_front();
               check("result", bus.out_result, want);
`ifdef FMA_STREAM_TAG_EN
               check("out_tag", 32'(bus.out_tag), 32'(tag_q.pop_front()));
`endif
            end
            n_pops <= n_pops + 1;
         end
         hold_prev <= bus.out_valid && !bus.out_ready;
         hold_val  <= bus.out_result;
`ifdef FMA_STREAM_TAG_EN
         hold_tag  <= bus.out_tag;
`endif
      end
   end

   // ---------------- driver ----------------
   // One cycle: drive inputs after the edge, sample acceptance at the negedge.
   task automatic drive(input logic iv, input fp32_t a, input fp32_t b, input fp32_t c,
                        input fp32_t want, input logic orr, output logic acc);
      @(posedge clk);
      #1;
      bus.in_valid  = iv;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_c      = c;
      bus.out_ready = orr;
`ifdef FMA_STREAM_TAG_EN
      bus.in_tag    = cur_tag;
`endif
      @(negedge clk);
      acc = iv && bus.in_ready;
      if (acc) begin
         exp_q.push_back(want);
`ifdef FMA_STREAM_TAG_EN
         tag_q.push_back(cur_tag);
`endif
      end
   endtask

   task automatic idle(input int n, input logic orr);
      logic acc;
      repeat (n) drive(1'b0, '0, '0, '0, '0, orr, acc);
   endtask

   // Fires one op and checks out_valid appears exactly LAT+1 cycles later.
   task automatic latency_test(input string name, input fp32_t a, input fp32_t b,
                               input fp32_t c, input fp32_t want);
      logic acc;
      drive(1'b1, a, b, c, want, 1'b1, acc);
      check({name, "_accept"}, 32'(acc), 32'd1);
      for (int k = 1; k <= LAT; k++) begin
         idle(1, 1'b1);
         check({name, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      end
      idle(1, 1'b1);
      check({name, "_valid_at_t6"}, 32'(bus.out_valid), 32'd1);
      check({name, "_occ_at_t6"}, 32'(occupancy), 32'd1);
      idle(1, 1'b1);
      check({name, "_occ_after_pop"}, 32'(occupancy), 32'd0);
      check({name, "_valid_after_pop"}, 32'(bus.out_valid), 32'd0);
   endtask

   // Watchdog: the bench must never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      logic acc;
      int   acc_cnt, peak, first_v, last_v, cnum, pops0;

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_c      = '0;
      bus.out_ready = 1'b0;
`ifdef FMA_STREAM_TAG_EN
      bus.in_tag    = '0;
`endif

      // ---- reset state ----
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_result", bus.out_result, 32'h0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_release", 32'(bus.in_ready), 32'd1);

      // ---- single op: 2.0*3.0+1.0 = 7.0 ----
      latency_test("single", 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40E00000);

      // ---- streaming 20 back-to-back ops ----
      peak = 0; first_v = -1; last_v = -1; cnum = 0; pops0 = n_pops;
      for (int i = 0; i < 30; i++) begin
         if (i < 20) begin
            drive(1'b1, enc(i + 1), enc(2), enc(1), enc(2 * i + 3), 1'b1, acc);
            check("stream_accept", 32'(acc), 32'd1);
         end else begin
            idle(1, 1'b1);
         end
         if (int'(occupancy) > peak) peak = int'(occupancy);
         if (bus.out_valid) begin
            if (first_v < 0) first_v = cnum;
            last_v = cnum;
         end
         cnum++;
      end
      check("stream_peak_occ", 32'(peak), 32'd6);
      check("stream_first_valid", 32'(first_v), 32'd6);
      check("stream_contiguous", 32'(last_v - first_v + 1), 32'd20);
      check("stream_pops", 32'(n_pops - pops0), 32'd20);
      check("stream_occ_end", 32'(occupancy), 32'd0);

      // ---- backpressure: 10 offered, 8 accepted ----
      acc_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, enc(i + 1), enc(3), enc(0), enc(3 * (i + 1)), 1'b0, acc);
         acc_cnt += int'(acc);
      end
      check("bp_accepted", 32'(acc_cnt), 32'd8);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      idle(8, 1'b0);
      check("bp_occ_full", 32'(occupancy), 32'd8);
      check("bp_head", bus.out_result, 32'h40400000);
      pops0 = n_pops;
      idle(1, 1'b1);
      check("bp_ready_still_low", 32'(bus.in_ready), 32'd0);
      idle(1, 1'b1);
      check("bp_ready_reassert", 32'(bus.in_ready), 32'd1);
      idle(8, 1'b1);
      check("bp_pops", 32'(n_pops - pops0), 32'd8);
      check("bp_occ_end", 32'(occupancy), 32'd0);

      // ---- full with simultaneous pop and push attempt ----
      for (int i = 0; i < 8; i++)
         drive(1'b1, enc(i + 1), enc(1), enc(10), enc(i + 11), 1'b0, acc);
      idle(7, 1'b0);
      check("full_occ", 32'(occupancy), 32'd8);
      pops0 = n_pops;
      drive(1'b1, enc(5), enc(5), enc(0), enc(25), 1'b1, acc);
      check("full_reject", 32'(acc), 32'd0);
      drive(1'b1, enc(5), enc(5), enc(0), enc(25), 1'b0, acc);
      check("full_occ_after_pop", 32'(occupancy), 32'd7);
      check("full_retry_accept", 32'(acc), 32'd1);
      idle(16, 1'b1);
      check("full_pops", 32'(n_pops - pops0), 32'd9);
      check("full_occ_end", 32'(occupancy), 32'd0);

      // ---- reset mid-flight ----
      for (int i = 0; i < 3; i++)
         drive(1'b1, enc(i + 2), enc(2), enc(0), enc(2 * (i + 2)), 1'b1, acc);
      idle(1, 1'b1);
      @(posedge clk);
      #1;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      exp_q.delete();
`ifdef FMA_STREAM_TAG_EN
      tag_q.delete();
`endif
      @(negedge clk);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         idle(1, 1'b1);
         check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
         check("midrst_occ", 32'(occupancy), 32'd0);
      end
      // 3.0*4.0+5.0 = 17.0
      latency_test("post_rst", 32'h40400000, 32'h40800000, 32'h40A00000, 32'h41880000);

`ifdef FMA_STREAM_TAG_EN
      // ---- tags under random backpressure ----
      begin
         logic [TAG_W-1:0] tags [3];
         tags[0] = 4'h3;
         tags[1] = 4'hA;
         tags[2] = 4'h5;
         for (int i = 0; i < 3; i++) begin
            cur_tag = tags[i];
            acc = 1'b0;
            for (int tries = 0; tries < 20 && !acc; tries++)
               drive(1'b1, enc(i + 6), enc(7), enc(1), enc((i + 6) * 7 + 1),
                     1'($urandom_range(0, 1)), acc);
            check("tag_accept", 32'(acc), 32'd1);
         end
         for (int k = 0; k < 60 && exp_q.size() != 0; k++)
            idle(1, 1'($urandom_range(0, 1)));
      end
`endif

      // ---- final drain: every expected result must have come out ----
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1, 1'b1);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
